fir_filter_param: RTL and testbench

- Parametrised successor to the fixed 4-tap FIR datapath: TAPS-tap direct-form FIR on signed samples, coefficients runtime-programmable through a write port.
- Sample stream uses the same valid-in/valid-out style (rin/r_out) with a global enable stall.
- Sits in the streaming datapath wherever a fixed-coefficient filter was previously instantiated.
- Full-precision internal accumulation; result scaled by an arithmetic right shift and narrowed to WIDTH.

---
 rtl/fir_filter_param.sv | 126 ++++++++++++
 tb/tb_fir_filter_param.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_param.sv
// fir_filter_param: TAPS-tap direct-form FIR on signed samples with
// runtime-programmable coefficients and a two-stage registered datapath.
//
// Optional build macro FIR_SAT_EN: saturate the shifted accumulator to the
// WIDTH range instead of wrapping, and add the sat_flag output.
//
// Stream handshake: there is no back-pressure. A sample is taken whenever
// enable && rin at a rising edge; r_out pulses for exactly one enabled cycle
// per accepted sample, two enabled edges after the accept. While enable is
// low every sample-path register holds and rin is ignored.
module fir_filter_param #(
  parameter int WIDTH = 16,
  parameter int TAPS  = 4,
  parameter int SHIFT = 0,
  parameter int AW    = $clog2(TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    rin,
  input  logic signed [WIDTH-1:0] dataIn1,
  input  logic                    coef_we,
  input  logic        [AW-1:0]    coef_addr,
  input  logic signed [WIDTH-1:0] coef_data,
`ifdef FIR_SAT_EN
  output logic                    sat_flag,
`endif
  output logic                    r_out,
  output logic signed [WIDTH-1:0] dataOut1
);

  localparam int PW    = 2 * WIDTH;
  localparam int ACC_W = PW + AW;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

  logic signed [WIDTH-1:0] xs_q [TAPS];
  logic signed [WIDTH-1:0] c_q  [TAPS];
  logic                    v1_q;
  logic                    r_out_q;
  logic signed [WIDTH-1:0] dout_q;
  logic signed [WIDTH-1:0] dout_d;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] shifted;
  logic                    clip;
`ifdef FIR_SAT_EN
  logic                    sat_q;
`endif

  // Stage-2 arithmetic: full-precision sum of products, shift, then narrow.
  always_comb begin
    prod  = '0;
    acc_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      prod  = PW'(xs_q[k]) * PW'(c_q[k]);
      acc_d = acc_d + ACC_W'(prod);
    end
    shifted = acc_d >>> SHIFT;
    clip    = 1'b0;
`ifdef FIR_SAT_EN
    if (shifted > SAT_MAX) begin
      dout_d = {1'b0, {(WIDTH-1){1'b1}}};
      clip   = 1'b1;
    end else if (shifted < SAT_MIN) begin
      dout_d = {1'b1, {(WIDTH-1){1'b0}}};
      clip   = 1'b1;
    end else begin
      dout_d = WIDTH'(shifted);
    end
`else
    dout_d = WIDTH'(shifted);
`endif
  end

  // Coefficient bank: writes land regardless of enable; addresses >= TAPS match no tap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) c_q[k] <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        if (coef_we && (coef_addr == AW'(k))) c_q[k] <= coef_data;
      end
    end
  end

  // Sample path: delay line shifts per accepted sample, two-stage valid pipeline.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) xs_q[k] <= '0;
      v1_q    <= 1'b0;
      r_out_q <= 1'b0;
      dout_q  <= '0;
`ifdef FIR_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else if (enable) begin
      if (rin) begin
        xs_q[0] <= dataIn1;
        for (int k = 1; k < TAPS; k++) xs_q[k] <= xs_q[k-1];
      end
      v1_q    <= rin;
      r_out_q <= v1_q;
      if (v1_q) dout_q <= dout_d;
`ifdef FIR_SAT_EN
      sat_q   <= v1_q && clip;
`endif
    end
  end

  assign r_out    = r_out_q;
  assign dataOut1 = dout_q;
`ifdef FIR_SAT_EN
  assign sat_flag = sat_q;
`else
  // Clip detection is only meaningful in the saturating build.
  logic unused_clip;
  assign unused_clip = clip;
`endif

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed testbench for fir_filter_param. Three instances share one set of
// input drivers: A (TAPS=4, SHIFT=0), B (TAPS=2, AW=2, SHIFT=0) and
// C (TAPS=2, SHIFT=15). Each test only inspects the instance it targets.
module tb_fir_filter_param;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        rin;
  logic [15:0] din;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [15:0] coef_data;

  logic        r_out_a, r_out_b, r_out_c;
  logic [15:0] dout_a, dout_b, dout_c;
`ifdef FIR_SAT_EN
  logic        sat_a, sat_b, sat_c;
`endif

  int n_checks;
  int n_errors;

  fir_filter_param #(.WIDTH(16), .TAPS(4), .SHIFT(0)) u_a (
    .clk(clk), .rst(rst), .enable(enable), .rin(rin), .dataIn1(din),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
`ifdef FIR_SAT_EN
    .sat_flag(sat_a),
`endif
    .r_out(r_out_a), .dataOut1(dout_a)
  );

  fir_filter_param #(.WIDTH(16), .TAPS(2), .SHIFT(0), .AW(2)) u_b (
    .clk(clk), .rst(rst), .enable(enable), .rin(rin), .dataIn1(din),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
`ifdef FIR_SAT_EN
    .sat_flag(sat_b),
`endif
    .r_out(r_out_b), .dataOut1(dout_b)
  );

  fir_filter_param #(.WIDTH(16), .TAPS(2), .SHIFT(15)) u_c (
    .clk(clk), .rst(rst), .enable(enable), .rin(rin), .dataIn1(din),
    .coef_we(coef_we), .coef_addr(coef_addr[0]), .coef_data(coef_data),
`ifdef FIR_SAT_EN
    .sat_flag(sat_c),
`endif
    .r_out(r_out_c), .dataOut1(dout_c)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable    = 1'b1;
    rin       = 1'b0;
    din       = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  task automatic wr_coef(input logic [1:0] a, input logic [15:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    step();
    coef_we   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst       = 1'b0;
    rin       = 1'b1;
    din       = 16'h0007;
    coef_we   = 1'b1;
    coef_addr = 2'd0;
    coef_data = 16'h0005;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (r_out_a !== 1'b0 || dout_a !== 16'h0000) begin
        n_errors++;
        $display("FAIL reset_hold[%0d] r_out=%b dataOut1=%h expected r_out=0 dataOut1=0000", i, r_out_a, dout_a);
      end
`ifdef FIR_SAT_EN
      n_checks++;
      if (sat_a !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_sat[%0d] sat_flag=%b expected 0", i, sat_a);
      end
`endif
    end
    // Coefficients must still be zero: a non-zero sample gives a zero result.
    rst     = 1'b1;
    coef_we = 1'b0;
    din     = 16'h0064;
    step();
    rin = 1'b0;
    n_checks++;
    if (r_out_a !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_first_edge r_out=%b expected 0", r_out_a);
    end
    step();
    n_checks++;
    if (r_out_a !== 1'b1 || dout_a !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_coef_zero r_out=%b dataOut1=%h expected r_out=1 dataOut1=0000", r_out_a, dout_a);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    wr_coef(2'd0, 16'h0001);
    rin = 1'b1;
    din = 16'h0003;
    step();
    rin = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (r_out_a !== 1'b0 || dout_a !== 16'h0000) begin
        n_errors++;
        $display("FAIL midreset[%0d] r_out=%b dataOut1=%h expected r_out=0 dataOut1=0000", i, r_out_a, dout_a);
      end
    end
  endtask

  task automatic test_impulse();
    logic [15:0] vin   [5] = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
    logic [15:0] exp_d [5] = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    do_reset();
    wr_coef(2'd0, 16'd4);
    wr_coef(2'd1, 16'd3);
    wr_coef(2'd2, 16'd2);
    wr_coef(2'd3, 16'd1);
    for (int i = 0; i < 7; i++) begin
      rin = (i < 5);
      din = (i < 5) ? vin[i] : 16'h0000;
      step();
      if (i == 0 || i == 6) begin
        n_checks++;
        if (r_out_a !== 1'b0) begin
          n_errors++;
          $display("FAIL impulse_idle[%0d] r_out=%b expected 0", i, r_out_a);
        end
      end else begin
        n_checks++;
        if (r_out_a !== 1'b1 || dout_a !== exp_d[i-1]) begin
          n_errors++;
          $display("FAIL impulse[%0d] r_out=%b dataOut1=%h expected r_out=1 dataOut1=%h", i-1, r_out_a, dout_a, exp_d[i-1]);
        end
      end
    end
    rin = 1'b0;
  endtask

  task automatic test_stall();
    logic        t_en  [13] = '{1,0,0,0,1,1,1,0,1,1,1,0,1};
    logic        t_rin [13] = '{1,1,1,1,0,1,0,0,1,0,0,1,0};
    logic [15:0] t_din [13] = '{1,9,9,9,0,0,0,0,0,0,0,5,0};
    logic        t_r   [13] = '{0,0,0,0,1,0,1,1,0,1,0,0,0};
    logic [15:0] t_d   [13] = '{0,0,0,0,4,4,3,3,3,2,2,2,2};
    do_reset();
    wr_coef(2'd0, 16'd4);
    wr_coef(2'd1, 16'd3);
    wr_coef(2'd2, 16'd2);
    wr_coef(2'd3, 16'd1);
    for (int i = 0; i < 13; i++) begin
      enable = t_en[i];
      rin    = t_rin[i];
      din    = t_din[i];
      step();
      n_checks++;
      if (r_out_a !== t_r[i] || dout_a !== t_d[i]) begin
        n_errors++;
        $display("FAIL stall[%0d] r_out=%b dataOut1=%h expected r_out=%b dataOut1=%h", i, r_out_a, dout_a, t_r[i], t_d[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_coef_update();
    logic [15:0] exp_d [9] = '{16'd8, 16'd14, 16'd18, 16'd20, 16'd20, 16'd32, 16'd32, 16'd32, 16'd32};
    do_reset();
    wr_coef(2'd0, 16'd4);
    wr_coef(2'd1, 16'd3);
    wr_coef(2'd2, 16'd2);
    wr_coef(2'd3, 16'd1);
    for (int i = 0; i < 10; i++) begin
      rin     = (i < 9);
      din     = 16'd2;
      coef_we = (i == 5);
      coef_addr = 2'd0;
      coef_data = 16'd10;
      step();
      coef_we = 1'b0;
      if (i >= 1) begin
        n_checks++;
        if (r_out_a !== 1'b1 || dout_a !== exp_d[i-1]) begin
          n_errors++;
          $display("FAIL coef_update[%0d] r_out=%b dataOut1=%h expected r_out=1 dataOut1=%h", i-1, r_out_a, dout_a, exp_d[i-1]);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    logic [15:0] e0, e1, e2;
    logic        f;
`ifdef FIR_SAT_EN
    e0 = 16'h7FFF; e1 = 16'h7FFF; e2 = 16'h7FFF; f = 1'b1;
`else
    e0 = 16'h0001; e1 = 16'h0002; e2 = 16'h8000; f = 1'b0;
`endif
    do_reset();
    wr_coef(2'd0, 16'h7FFF);
    wr_coef(2'd1, 16'h7FFF);
    rin = 1'b1;
    din = 16'h7FFF;
    step();
    step();
    rin = 1'b0;
    n_checks++;
    if (r_out_b !== 1'b1 || dout_b !== e0) begin
      n_errors++;
      $display("FAIL overflow_first r_out=%b dataOut1=%h expected r_out=1 dataOut1=%h", r_out_b, dout_b, e0);
    end
`ifdef FIR_SAT_EN
    n_checks++;
    if (sat_b !== f) begin
      n_errors++;
      $display("FAIL overflow_first_sat sat_flag=%b expected %b", sat_b, f);
    end
`endif
    step();
    n_checks++;
    if (r_out_b !== 1'b1 || dout_b !== e1) begin
      n_errors++;
      $display("FAIL overflow_second r_out=%b dataOut1=%h expected r_out=1 dataOut1=%h", r_out_b, dout_b, e1);
    end
`ifdef FIR_SAT_EN
    n_checks++;
    if (sat_b !== f) begin
      n_errors++;
      $display("FAIL overflow_second_sat sat_flag=%b expected %b", sat_b, f);
    end
`endif
    // Writes beyond the last tap must leave c0/c1 untouched.
    wr_coef(2'd2, 16'h0005);
`ifdef FIR_SAT_EN
    n_checks++;
    if (sat_b !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_clear sat_flag=%b expected 0", sat_b);
    end
`endif
    wr_coef(2'd3, 16'h0005);
    rin = 1'b1;
    din = 16'h0001;
    step();
    rin = 1'b0;
    step();
    n_checks++;
    if (r_out_b !== 1'b1 || dout_b !== e2) begin
      n_errors++;
      $display("FAIL addr_range r_out=%b dataOut1=%h expected r_out=1 dataOut1=%h", r_out_b, dout_b, e2);
    end
  endtask

  task automatic test_shift_negative();
    do_reset();
    wr_coef(2'd0, 16'h7FFF);
    rin = 1'b1;
    din = 16'h8000;
    step();
    rin = 1'b0;
    step();
    n_checks++;
    if (r_out_c !== 1'b1 || dout_c !== 16'h8001) begin
      n_errors++;
      $display("FAIL shift_neg r_out=%b dataOut1=%h expected r_out=1 dataOut1=8001", r_out_c, dout_c);
    end
`ifdef FIR_SAT_EN
    n_checks++;
    if (sat_c !== 1'b0) begin
      n_errors++;
      $display("FAIL shift_neg_sat sat_flag=%b expected 0", sat_c);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_reset_midstream();
    test_impulse();
    test_stall();
    test_coef_update();
    test_overflow();
    test_shift_negative();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
